// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 pipeline: instruction codes, ALU functions,
// branch/move conditions, status codes, and the condition evaluator.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Unknown condition codes resolve to "not taken".
  function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                     input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (ifun)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | zf;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = zf;
      C_NE:     cond_eval = ~zf;
      C_GE:     cond_eval = ~lt;
      C_G:      cond_eval = ~lt & ~zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: computes b OP a and the ZF/SF/OF flags.
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_fun_e     fun,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  always_comb begin
    result = b + a;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = b + a;
        of     = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = b + a;
    endcase
    zf = (result == '0);
    sf = result[W-1];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU operand selection, condition
// codes and Cnd resolution, with results presented combinationally downstream.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E_bubble,
  input  logic         E_stall,
  input  logic [2:0]   d_stat,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_ifun,
  input  logic [W-1:0] d_valC,
  input  logic [W-1:0] d_valA,
  input  logic [W-1:0] d_valB,
  input  logic [3:0]   d_dstE,
  input  logic [3:0]   d_dstM,
  input  logic [3:0]   d_srcA,
  input  logic [3:0]   d_srcB,
  input  logic [2:0]   m_stat,
  input  logic [2:0]   W_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_dstM,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB,
  output logic [2:0]   e_stat,
  output logic [3:0]   e_icode,
  output logic [3:0]   e_ifun,
  output logic         e_Cnd,
  output logic [W-1:0] e_valE,
  output logic [W-1:0] e_valA,
  output logic [3:0]   e_dstE,
  output logic [3:0]   e_dstM,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  import y86_pkg::*;

  typedef struct packed {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valC;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
  } ereg_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam ereg_t E_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    valC:  '0,
    valA:  '0,
    valB:  '0,
    dstE:  RNONE,
    dstM:  RNONE,
    srcA:  RNONE,
    srcB:  RNONE
  };

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  ereg_t        e_q, e_d;
  cc_t          cc_q, cc_d;
  logic [W-1:0] alu_a, alu_b, alu_r;
  alu_fun_e     alu_fun;
  logic         alu_zf, alu_sf, alu_of;
  logic         set_cc;

  // Bubble wins over stall so a squashed instruction never lingers.
  always_comb begin
    e_d = e_q;
    if (E_bubble) begin
      e_d = E_BUBBLE;
    end else if (!E_stall) begin
      e_d.stat  = d_stat;
      e_d.icode = d_icode;
      e_d.ifun  = d_ifun;
      e_d.valC  = d_valC;
      e_d.valA  = d_valA;
      e_d.valB  = d_valB;
      e_d.dstE  = d_dstE;
      e_d.dstM  = d_dstM;
      e_d.srcA  = d_srcA;
      e_d.srcB  = d_srcB;
    end
  end

  always_comb begin
    alu_a = '0;
    case (e_q.icode)
      I_RRMOVQ, I_OPQ:             alu_a = e_q.valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_q.valC;
      I_CALL, I_PUSHQ:             alu_a = '0 - W'(8);
      I_RET, I_POPQ:               alu_a = W'(8);
      default:                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (e_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = e_q.valB;
      default:                                                   alu_b = '0;
    endcase
  end

  // Out-of-range OPq functions fall back to add; decode already raised INS.
  always_comb begin
    alu_fun = ALU_ADD;
    if (e_q.icode == I_OPQ && e_q.ifun[3:2] == 2'b00) begin
      alu_fun = alu_fun_e'(e_q.ifun[1:0]);
    end
  end

  y86_alu #(.W(W)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fun    (alu_fun),
    .result (alu_r),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // A downstream exception blocks the flag write in the very same cycle.
  assign set_cc = (e_q.icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);

  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d.zf = alu_zf;
      cc_d.sf = alu_sf;
      cc_d.of = alu_of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q  <= E_BUBBLE;
      cc_q <= CC_RESET;
    end else begin
      e_q  <= e_d;
      cc_q <= cc_d;
    end
  end

  always_comb begin
    e_Cnd = 1'b0;
    if (e_q.icode == I_RRMOVQ || e_q.icode == I_JXX) begin
      e_Cnd = cond_eval(e_q.ifun, cc_q.zf, cc_q.sf, cc_q.of);
    end
  end

  assign e_dstE  = (e_q.icode == I_RRMOVQ && !e_Cnd) ? RNONE : e_q.dstE;
  assign e_valE  = alu_r;
  assign e_valA  = e_q.valA;
  assign e_stat  = e_q.stat;
  assign e_icode = e_q.icode;
  assign e_ifun  = e_q.ifun;
  assign e_dstM  = e_q.dstM;

  assign E_icode = e_q.icode;
  assign E_dstM  = e_q.dstM;
  assign E_srcA  = e_q.srcA;
  assign E_srcB  = e_q.srcB;

  assign cc_zf = cc_q.zf;
  assign cc_sf = cc_q.sf;
  assign cc_of = cc_q.of;

endmodule
